control_word_sequencer: RTL and testbench

// Parametrised hardware sequencer that replays a stored program of control words into
// the LEGv8 datapath. Each program step pairs a control word with a constant. The block

---
 rtl/control_word_sequencer.sv | 108 ++++++++++
 tb/tb_control_word_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/control_word_sequencer.sv
// control_word_sequencer: replays a stored control-word/constant program into the LEGv8 datapath
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   load_en/addr/cw/k write one program slot (IDLE only)
//   start, length     run `length` steps from slot 0 (clamped to DEPTH, IDLE only)
//   abort             cancel the run, no done pulse
//   mem_ready         memory finishes the current memory-flagged step
//   cw_out, k_out     registered control word / constant to the datapath (0 = NOP)
//   cw_valid, pc      live-step flag and slot index of the step on cw_out
//   busy, done        run in progress / one-cycle completion pulse
//   stall_count       saturating count of stalled cycles in the last/current run
module control_word_sequencer #(
    parameter int CW_WIDTH     = 32,
    parameter int K_WIDTH      = 64,
    parameter int DEPTH        = 16,
    parameter int MEM_FLAG_BIT = 9,
    parameter int CNT_WIDTH    = 16,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [AW-1:0]        load_addr,
    input  logic [CW_WIDTH-1:0]  load_cw,
    input  logic [K_WIDTH-1:0]   load_k,
    input  logic                 start,
    input  logic [AW:0]          length,
    input  logic                 abort,
    input  logic                 mem_ready,
    output logic [CW_WIDTH-1:0]  cw_out,
    output logic [K_WIDTH-1:0]   k_out,
    output logic                 cw_valid,
    output logic [AW-1:0]        pc,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] stall_count
);
    typedef enum logic {IDLE, ISSUE} state_t;
    localparam logic [AW:0] NMAX = (AW+1)'(DEPTH);
    state_t              state_q;
    logic [AW:0]         n_q;
    logic [CW_WIDTH-1:0] cw_mem [DEPTH];
    logic [K_WIDTH-1:0]  k_mem  [DEPTH];
    logic [AW-1:0]       pc_d;
    logic                consume, last, hit0;
    logic [CW_WIDTH-1:0] cw0_d;
    logic [K_WIDTH-1:0]  k0_d;
    always_comb begin
        pc_d    = pc + AW'(1);
        consume = cw_valid && (!cw_out[MEM_FLAG_BIT] || mem_ready);
        last    = ({1'b0, pc} + (AW+1)'(1)) == n_q;
        // a load to slot 0 in the start cycle must be visible to the first step
        hit0    = load_en && load_addr == '0;
        cw0_d   = hit0 ? load_cw : cw_mem[0];
        k0_d    = hit0 ? load_k : k_mem[0];
        busy    = state_q == ISSUE;
    end
    // program storage survives reset
    always_ff @(posedge clock)
        if (state_q == IDLE && load_en) begin
            cw_mem[load_addr] <= load_cw;
            k_mem[load_addr]  <= load_k;
        end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cw_out      <= '0;
            k_out       <= '0;
            cw_valid    <= 1'b0;
            pc          <= '0;
            done        <= 1'b0;
            stall_count <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state_q  <= IDLE;
                cw_out   <= '0;
                k_out    <= '0;
                cw_valid <= 1'b0;
            end else if (state_q == IDLE) begin
                if (start && length == '0)
                    done <= 1'b1;
                else if (start) begin
                    state_q     <= ISSUE;
                    n_q         <= length > NMAX ? NMAX : length;
                    stall_count <= '0;
                    cw_out      <= cw0_d;
                    k_out       <= k0_d;
                    cw_valid    <= 1'b1;
                    pc          <= '0;
                end
            end else if (consume && last) begin
                state_q  <= IDLE;
                cw_out   <= '0;
                k_out    <= '0;
                cw_valid <= 1'b0;
                done     <= 1'b1;
            end else if (consume) begin
                pc     <= pc_d;
                cw_out <= cw_mem[pc_d];
                k_out  <= k_mem[pc_d];
            end else if (stall_count != '1)
                stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_control_word_sequencer.sv
// tb_control_word_sequencer: directed bench with a per-cycle reference model of the sequencer
module tb_control_word_sequencer;
    logic        clk = 1'b0;
    logic        rst, load_en, start, abort, mem_ready;
    logic [3:0]  load_addr;
    logic [31:0] load_cw;
    logic [63:0] load_k;
    logic [4:0]  length;
    logic [31:0] cw_out;
    logic [63:0] k_out;
    logic        cw_valid, busy, done;
    logic [3:0]  pc;
    logic [15:0] stall_count;
    int total = 0, bad = 0;
    bit chk_en = 0;
    logic [31:0] p_cw [16];
    logic [63:0] p_k  [16];
    bit          m_run = 0, m_done = 0;
    logic [3:0]  m_pc = '0;
    logic [15:0] m_stall = '0;
    int          m_n = 0;
    int          cnt, maxpc;

    always #5 clk = ~clk;

    control_word_sequencer dut (
        .clock(clk), .reset(rst), .load_en(load_en), .load_addr(load_addr),
        .load_cw(load_cw), .load_k(load_k), .start(start), .length(length),
        .abort(abort), .mem_ready(mem_ready), .cw_out(cw_out), .k_out(k_out),
        .cw_valid(cw_valid), .pc(pc), .busy(busy), .done(done),
        .stall_count(stall_count)
    );

    task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference: a run is "step m_pc of m_n"; outputs are derived from the program arrays.
    task automatic model();
        if (rst) begin
            m_run = 0; m_done = 0; m_pc = '0; m_stall = '0;
        end else begin
            m_done = 0;
            if (!m_run && load_en) begin
                p_cw[load_addr] = load_cw;
                p_k[load_addr]  = load_k;
            end
            if (abort) m_run = 0;
            else if (!m_run) begin
                if (start && length == 0) m_done = 1;
                else if (start) begin
                    m_run = 1; m_pc = '0; m_stall = '0;
                    m_n = length > 16 ? 16 : int'(length);
                end
            end else if (!p_cw[m_pc][9] || mem_ready) begin
                if (int'(m_pc) == m_n - 1) begin
                    m_run = 0; m_done = 1;
                end else m_pc++;
            end else if (m_stall != 16'hFFFF) m_stall++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        @(negedge clk);
    endtask

    task automatic load(int a, logic [31:0] c, logic [63:0] k);
        load_en = 1; load_addr = 4'(a); load_cw = c; load_k = k;
        tick();
        load_en = 0;
    endtask

    always @(negedge clk)
        if (chk_en) begin
            cmp("m_cw_out", cw_out, m_run ? p_cw[m_pc] : 32'h0);
            cmp("m_k_out", k_out, m_run ? p_k[m_pc] : 64'h0);
            cmp("m_cw_valid", cw_valid, m_run);
            cmp("m_busy", busy, m_run);
            cmp("m_done", done, m_done);
            cmp("m_pc", pc, m_pc);
            cmp("m_stall", stall_count, m_stall);
        end

    initial begin
        rst = 1; load_en = 0; start = 0; abort = 0; mem_ready = 0;
        load_addr = '0; load_cw = '0; load_k = '0; length = '0;
        tick(); tick();
        rst = 0;
        chk_en = 1;
        // 1: program survives a 2-cycle reset
        load(0, 32'h010987E0, 64'd24);
        load(1, 32'h0, 64'd0);
        rst = 1; tick(); tick(); rst = 0;
        cmp("rst_cw", cw_out, 0); cmp("rst_k", k_out, 0); cmp("rst_valid", cw_valid, 0);
        cmp("rst_pc", pc, 0); cmp("rst_busy", busy, 0); cmp("rst_done", done, 0);
        cmp("rst_stall", stall_count, 0);
        // 2: two-step run
        length = 2; start = 1; mem_ready = 1; tick(); start = 0;
        cmp("t2_cw0", cw_out, 32'h010987E0); cmp("t2_k0", k_out, 24);
        cmp("t2_pc0", pc, 0); cmp("t2_v0", cw_valid, 1);
        tick();
        cmp("t2_pc1", pc, 1); cmp("t2_cw1", cw_out, 0); cmp("t2_v1", cw_valid, 1);
        tick();
        cmp("t2_done", done, 1); cmp("t2_vend", cw_valid, 0); cmp("t2_stall", stall_count, 0);
        tick();
        cmp("t2_done_off", done, 0);
        // 3: memory stall on slot 1
        load(1, 32'h200, 64'd5);
        length = 2; start = 1; mem_ready = 1; tick(); start = 0;
        tick();
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cmp("t3_hold_pc", pc, 1); cmp("t3_hold_cw", cw_out, 32'h200);
            tick();
        end
        cmp("t3_hold_last", pc, 1); cmp("t3_stall_run", stall_count, 3);
        mem_ready = 1; tick();
        cmp("t3_done", done, 1); cmp("t3_stall", stall_count, 3);
        tick();
        // 4: length 0 and clamping
        length = 0; start = 1; tick(); start = 0;
        cmp("t4_len0_done", done, 1); cmp("t4_len0_valid", cw_valid, 0);
        tick();
        cmp("t4_len0_once", done, 0);
        for (int i = 0; i < 16; i++) load(i, 32'h1000 * (i + 1), 64'(i * 3));
        length = 20; start = 1; tick(); start = 0;
        cnt = 0; maxpc = 0;
        repeat (20) begin
            if (cw_valid) begin
                cnt++;
                if (int'(pc) > maxpc) maxpc = int'(pc);
            end
            tick();
        end
        cmp("t4_steps", 64'(cnt), 16); cmp("t4_maxpc", 64'(maxpc), 15);
        // 5: start/load ignored mid-run
        length = 5; start = 1; tick(); start = 0;
        tick();
        start = 1; length = 3; load_en = 1; load_addr = 0; load_cw = 32'hDEAD0000; load_k = 64'd9;
        tick();
        start = 0; load_en = 0;
        cmp("t5_pc", pc, 2);
        repeat (4) tick();
        length = 1; start = 1; tick(); start = 0;
        cmp("t5_slot0", cw_out, 32'h1000); cmp("t5_k0", k_out, 0);
        tick(); tick();
        // 6: abort at pc 2
        length = 5; start = 1; tick(); start = 0;
        tick(); tick();
        cmp("t6_pc2", pc, 2);
        abort = 1; tick(); abort = 0;
        cmp("t6_valid", cw_valid, 0); cmp("t6_cw", cw_out, 0); cmp("t6_done", done, 0);
        tick();
        cmp("t6_no_done", done, 0);
        length = 2; start = 1; tick(); start = 0;
        cmp("t6_rerun_pc", pc, 0); cmp("t6_rerun_cw", cw_out, 32'h1000); cmp("t6_rerun_v", cw_valid, 1);
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
